// File: rtl/memory_snoop_collector_pkg.sv
// Shared types and constants for the snoop broadcast/collect engine.
package mem_snoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BCAST,
    ST_COLLECT,
    ST_RESPOND
  } snoop_state_e;

  // Snoop request types
  localparam logic [2:0] SNOOP_READ_SHARED   = 3'b000;
  localparam logic [2:0] SNOOP_READ_UNIQUE   = 3'b001;
  localparam logic [2:0] SNOOP_CLEAN_INVALID = 3'b010;
  localparam logic [2:0] SNOOP_MAKE_INVALID  = 3'b011;
  localparam logic [2:0] SNOOP_CLEAN_SHARED  = 3'b100;

  // Agent / merged response codes
  localparam logic [2:0] SNOOP_RSP_NONE       = 3'b000;
  localparam logic [2:0] SNOOP_RSP_SHARED     = 3'b001;
  localparam logic [2:0] SNOOP_RSP_UNIQUE     = 3'b010;
  localparam logic [2:0] SNOOP_RSP_PASS_DIRTY = 3'b011;
  localparam logic [2:0] SNOOP_RSP_ERROR      = 3'b100;

  // Lower agent index wins the merged response code.
  function automatic logic code_takes_priority(input int unsigned cand_idx,
                                               input int unsigned held_idx);
    return cand_idx < held_idx;
  endfunction

endpackage

// File: rtl/memory_snoop_collector_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count up on inc, hold at all-ones, clear on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          count_q <= '0;
    else if (clr)                        count_q <= '0;
    else if (inc && (count_q != '1))     count_q <= count_q + WIDTH'(1);
  end

  assign count = count_q;

endmodule

// File: rtl/memory_snoop_collector.sv
// Snoop engine: broadcasts one snoop to enabled agents, merges their
// responses under a timeout, returns one response and keeps statistics.
module memory_snoop_collector
  import mem_snoop_pkg::*;
#(
  parameter int unsigned NUM_AGENTS     = 12,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    snoop_req_valid,
  output logic                    snoop_req_ready,
  input  logic [ADDR_WIDTH-1:0]   snoop_req_addr,
  input  logic [2:0]              snoop_req_type,
  input  logic [NUM_AGENTS-1:0]   agent_enable,
  output logic [NUM_AGENTS-1:0]   agent_snoop_valid,
  output logic [ADDR_WIDTH-1:0]   agent_snoop_addr,
  output logic [2:0]              agent_snoop_type,
  input  logic [NUM_AGENTS-1:0]   agent_resp_valid,
  input  logic [NUM_AGENTS-1:0]   agent_resp_hit,
  input  logic [NUM_AGENTS-1:0]   agent_resp_dirty,
  input  logic [NUM_AGENTS*3-1:0] agent_resp_code,
  output logic                    snoop_rsp_valid,
  input  logic                    snoop_rsp_ready,
  output logic                    snoop_rsp_hit,
  output logic                    snoop_rsp_dirty,
  output logic [2:0]              snoop_rsp_code,
  output logic                    snoop_rsp_timeout,
  output logic [NUM_AGENTS-1:0]   snoop_rsp_missing,
  input  logic                    perf_clear,
  output logic [CNT_WIDTH-1:0]    snoop_count,
  output logic [CNT_WIDTH-1:0]    snoop_hit_count,
  output logic [CNT_WIDTH-1:0]    snoop_timeout_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IW = $clog2(NUM_AGENTS + 1);

  snoop_state_e          state_q, state_d;
  logic [NUM_AGENTS-1:0] pending_q, pending_d;
  logic                  hit_q, hit_d, dirty_q, dirty_d;
  logic [2:0]            code_q, code_d;
  logic [IW-1:0]         code_idx_q, code_idx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_AGENTS-1:0] missing_q, missing_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            type_q, type_d;

  logic [NUM_AGENTS-1:0] resp_take;
  logic                  cand_found;
  logic [IW-1:0]         cand_idx;
  logic [2:0]            cand_code;
  logic                  rsp_hs;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      hit_q      <= 1'b0;
      dirty_q    <= 1'b0;
      code_q     <= SNOOP_RSP_NONE;
      code_idx_q <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      missing_q  <= '0;
      addr_q     <= '0;
      type_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      hit_q      <= hit_d;
      dirty_q    <= dirty_d;
      code_q     <= code_d;
      code_idx_q <= code_idx_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      missing_q  <= missing_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
    end
  end

  // Next-state: accept, broadcast, collect with timeout, hold response.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    hit_d      = hit_q;
    dirty_d    = dirty_q;
    code_d     = code_q;
    code_idx_d = code_idx_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    missing_d  = missing_q;
    addr_d     = addr_q;
    type_d     = type_q;

    resp_take  = agent_resp_valid & pending_q;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_code  = SNOOP_RSP_NONE;
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      if (!cand_found && resp_take[i] && agent_resp_hit[i] &&
          (agent_resp_code[i*3 +: 3] != SNOOP_RSP_NONE)) begin
        cand_found = 1'b1;
        cand_idx   = IW'(i);
        cand_code  = agent_resp_code[i*3 +: 3];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (snoop_req_valid) begin
          addr_d     = snoop_req_addr;
          type_d     = snoop_req_type;
          pending_d  = agent_enable;
          hit_d      = 1'b0;
          dirty_d    = 1'b0;
          code_d     = SNOOP_RSP_NONE;
          code_idx_d = IW'(NUM_AGENTS);
          timer_d    = '0;
          timeout_d  = 1'b0;
          missing_d  = '0;
          state_d    = (agent_enable != '0) ? ST_BCAST : ST_RESPOND;
        end
      end
      ST_BCAST: state_d = ST_COLLECT;
      ST_COLLECT: begin
        hit_d     = hit_q   | (|(resp_take & agent_resp_hit));
        dirty_d   = dirty_q | (|(resp_take & agent_resp_dirty));
        pending_d = pending_q & ~resp_take;
        // code_idx_q starts at NUM_AGENTS so any qualifying agent wins first.
        if (cand_found && code_takes_priority(32'(cand_idx), 32'(code_idx_q))) begin
          code_d     = cand_code;
          code_idx_d = cand_idx;
        end
        if (pending_d == '0) begin
          state_d = ST_RESPOND;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_RESPOND;
          timeout_d = 1'b1;
          missing_d = pending_d;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESPOND: if (snoop_rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign snoop_req_ready   = (state_q == ST_IDLE);
  assign agent_snoop_valid = (state_q == ST_BCAST) ? pending_q : '0;
  assign agent_snoop_addr  = addr_q;
  assign agent_snoop_type  = type_q;
  assign snoop_rsp_valid   = (state_q == ST_RESPOND);
  assign snoop_rsp_hit     = hit_q;
  assign snoop_rsp_dirty   = dirty_q;
  assign snoop_rsp_code    = code_q;
  assign snoop_rsp_timeout = timeout_q;
  assign snoop_rsp_missing = missing_q;
  assign rsp_hs            = snoop_rsp_valid & snoop_rsp_ready;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_snoop (
    .clk(clk), .rst_n(rst_n), .clr(perf_clear), .inc(rsp_hs), .count(snoop_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_hit (
    .clk(clk), .rst_n(rst_n), .clr(perf_clear), .inc(rsp_hs & hit_q), .count(snoop_hit_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_timeout (
    .clk(clk), .rst_n(rst_n), .clr(perf_clear), .inc(rsp_hs & timeout_q),
    .count(snoop_timeout_count)
  );

endmodule

// File: doc/memory_snoop_collector.md
# memory_snoop_collector

Parametrised snoop broadcast/collect engine for the memory subsystem. It accepts one coherency snoop at a time from the interconnect and broadcasts it to NUM_AGENTS cache agents (L1 I/D, L2, L3 slices). It collects their multi-cycle responses under a per-snoop timeout and returns one merged hit/dirty/code response. It keeps saturating snoop statistics, and so replaces the single-cycle combinational snoop OR-tree.

## Interface
- NUM_AGENTS, 12, number of snooped cache agents (≥1)
- ADDR_WIDTH, 64, snoop address width
- TIMEOUT_CYCLES, 64, maximum COLLECT cycles before forced response (≥1)
- CNT_WIDTH, 32, statistics counter width

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- snoop_req_valid  in  1  upstream snoop request
- snoop_req_ready  out  1  high in IDLE only
- snoop_req_addr  in  ADDR_WIDTH  snoop address
- snoop_req_type  in  3  snoop type
- agent_enable  in  NUM_AGENTS  agents participating, sampled at request accept
- agent_snoop_valid  out  NUM_AGENTS  one-cycle broadcast pulse per enabled agent
- agent_snoop_addr  out  ADDR_WIDTH  latched address
- agent_snoop_type  out  3  latched type
- agent_resp_valid  in  NUM_AGENTS  per-agent response strobe
- agent_resp_hit  in  NUM_AGENTS  per-agent hit
- agent_resp_dirty  in  NUM_AGENTS  per-agent dirty
- agent_resp_code  in  NUM_AGENTS×3  per-agent response code
- snoop_rsp_valid  out  1  merged response valid
- snoop_rsp_ready  in  1  upstream accepts response
- snoop_rsp_hit / snoop_rsp_dirty  out  1 each  merged flags
- snoop_rsp_code  out  3  merged code
- snoop_rsp_timeout  out  1  at least one agent failed to answer
- snoop_rsp_missing  out  NUM_AGENTS  agents still pending at timeout
- perf_clear  in  1  synchronous clear of all counters
- snoop_count, snoop_hit_count, snoop_timeout_count  out  CNT_WIDTH each  statistics

## Operation
The FSM has four states: IDLE, BCAST, COLLECT and RESPOND.

- **IDLE**
  - snoop_req_ready=1.
  - On snoop_req_valid, latch addr and type. Set pending = agent_enable. Clear the accumulators and the timer.
  - Next state is BCAST if pending≠0. Otherwise go straight to RESPOND with a clean miss (hit=dirty=0, code=0, timeout=0).
- **BCAST**
  - agent_snoop_valid = pending for exactly this cycle. Next state is COLLECT.
- **COLLECT**
  - Each cycle, for every agent i with agent_resp_valid[i] & pending[i]:
    - OR hit[i] into the hit accumulator.
    - OR dirty[i] into the dirty accumulator.
    - Clear pending[i].
  - Responses from non-pending agents are ignored. Duplicate responses after an agent's bit has cleared are ignored.
  - Code merge: the lowest-index agent whose response has hit=1 and code≠0 supplies snoop_rsp_code. Across cycles, a lower-index agent overrides an earlier captured code. If no agent qualifies, code is 0.
  - If pending becomes 0 this cycle, go to RESPOND.
  - Else if timer==TIMEOUT_CYCLES-1, go to RESPOND with timeout=1 and missing=remaining pending.
  - Otherwise timer++.
- **RESPOND**
  - snoop_rsp_valid=1. All response fields are held stable until snoop_rsp_ready.
  - On handshake, go to IDLE.
- **Invariants**
  - agent_enable changes after accept do not affect the in-flight snoop.
  - agent_snoop_addr and agent_snoop_type hold the latched values until the next accept.
- **Counters**
  - Counters update on the response handshake:
    - snoop_count +1.
    - snoop_hit_count +1 if hit.
    - snoop_timeout_count +1 if timeout.
  - Each counter saturates at all-ones.
  - perf_clear wins over a simultaneous increment.

## Timing
- Reset values:
  - State=IDLE, so snoop_req_ready=1.
  - All other outputs are 0: agent_snoop_valid, snoop_rsp_*, agent_snoop_addr, agent_snoop_type, and the counters.
- Reset mid-operation aborts the transaction immediately. No response is issued and no counters change.
- Latencies:
  - Request accepted in cycle T: pulse in T+1.
  - If all agents respond in T+2, snoop_rsp_valid rises in T+3.
  - Empty enable mask: snoop_rsp_valid rises in T+1.
  - Timeout: snoop_rsp_valid rises in T+2+TIMEOUT_CYCLES.
- Response window: agents may respond no earlier than the cycle after their pulse. Responses present in the BCAST cycle are ignored.
- A response arriving on the final COLLECT cycle is counted before the timeout check. If it completes the mask, timeout=0.
- Back-to-back snoops: the next request is accepted the cycle after the response handshake. There is no overlap.
- Timer width: $clog2(TIMEOUT_CYCLES+1).

## Structure
- Package mem_snoop_pkg holds:
  - the FSM state enum (snoop_state_e);
  - the 3-bit snoop type constants;
  - the response code constants (SNOOP_RSP_NONE=3'b000 etc.);
  - a merge-priority function.
- Sub-module sat_counter is instantiated three times. It has parameter WIDTH and ports clk, rst_n, clr, inc, and count.

## Test plan
- **All respond at once:** NUM_AGENTS=4, enable=4'b1111. All agents respond in T+2; agent2 has hit=1, dirty=1, code=3'b010.
  - Expected: rsp_valid in T+3, hit=1, dirty=1, code=010, timeout=0, snoop_count=1, snoop_hit_count=1.
- **Staggered, code priority:** agent3 (hit, code 3'b100) answers at T+2; agent1 (hit, code 3'b001) answers at T+5.
  - Expected: code=001, rsp_valid at T+6.
- **Timeout:** TIMEOUT_CYCLES=8, agent0 never responds.
  - Expected: rsp_valid at T+10, timeout=1, missing=4'b0001, snoop_timeout_count=1.
- **Empty mask and backpressure:** enable=0 with snoop_rsp_ready held low for 5 cycles.
  - Expected: rsp_valid at T+1, fields stable for the 5 cycles, no agent_snoop_valid pulse, snoop_req_ready=0 until the handshake.
- **Filtering:** a non-enabled agent responds; an enabled agent responds twice.
  - Expected: both the stray and the duplicate response are ignored; the merged result is unchanged.
- **Reset and counter edge cases:**
  - Assert rst_n low during COLLECT: outputs return to reset values, with no response and no count.
  - Preload counters to all-ones via CNT_WIDTH=4 and issue 20 snoops: they saturate at 4'hF.
  - Assert perf_clear together with a handshake: the count becomes 0.
